// File: rtl/host_loader_pkg.sv
// Shared definitions for the host command bridge: opcodes, reply codes and
// the frame-level state encoding.
package host_loader_pkg;

   localparam logic [7:0] OP_WRITE      = 8'h01;
   localparam logic [7:0] OP_READ       = 8'h02;
   localparam logic [7:0] OP_CONTROL    = 8'h03;
   localparam logic [7:0] OP_STATUS     = 8'h04;
   localparam logic [7:0] REPLY_BAD_OP  = 8'hEE;
   localparam logic [7:0] REPLY_TIMEOUT = 8'hEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARGS = 2'd1,
      ST_WB   = 2'd2,
      ST_RESP = 2'd3
   } loaderState_t;

   // Number of argument bytes that follow an opcode; zero for argument-less ones.
   function automatic logic [2:0] argCount(input logic [7:0] op);
      case (op)
         OP_WRITE:   argCount = 3'd5;
         OP_READ:    argCount = 3'd3;
         OP_CONTROL: argCount = 3'd2;
         default:    argCount = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/host_reply_tx.sv
// Reply serializer: loads up to three bytes (MSB first) and streams them out
// over a valid/ready byte interface, pulsing done as the last byte leaves.
module host_reply_tx (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [23:0] loadBuf,
   input  logic [1:0]  loadLen,
   output logic [7:0]  txData,
   output logic        txValid,
   input  logic        txReady,
   output logic        done
);

   logic [23:0] bufR;
   logic [1:0]  remR;

   // The head byte always sits in the top of the buffer, so txData holds while stalled.
   assign txData = bufR[23:16];
   assign done   = txValid && txReady && (remR == 2'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         bufR    <= '0;
         remR    <= '0;
         txValid <= 1'b0;
      end else if (load) begin
         bufR    <= loadBuf;
         remR    <= loadLen;
         txValid <= 1'b1;
      end else if (txValid && txReady) begin
         bufR <= {bufR[15:0], 8'h00};
         remR <= remR - 2'd1;
         if (remR == 2'd1) begin
            txValid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/host_loader.sv
// Host command bridge: parses framed byte commands, runs Wishbone single
// transfers, drives controlReg and returns a fixed-format reply per command.
// Handshakes: a byte moves on any cycle where valid && ready; valid never waits on ready.
module host_loader
   import host_loader_pkg::*;
#(
   parameter int          ADDRESS_WIDTH = 24,
   parameter logic [15:0] WB_TIMEOUT    = 16'd1023,
   parameter logic [15:0] CONTROL_RESET = 16'h0001
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               rxData,
   input  logic                     rxValid,
   output logic                     rxReady,
   output logic [7:0]               txData,
   output logic                     txValid,
   input  logic                     txReady,
   output logic [ADDRESS_WIDTH-1:0] wbAdrO,
   output logic [15:0]              wbDatO,
   input  logic [15:0]              wbDatI,
   output logic                     wbCycO,
   output logic                     wbStbO,
   output logic                     wbWeO,
   input  logic                     wbAckI,
   output logic [15:0]              controlReg,
   input  logic [15:0]              statusReg,
   output logic [1:0]               stateDbg
);

   loaderState_t state, nextState;

   logic [7:0]  opR;
   logic [2:0]  argCnt;
   logic [31:0] argShift;
   logic [15:0] toCnt;

   logic        rxFire;
   logic [39:0] newArgs;
   logic [23:0] hostAdr;
   logic        load;
   logic [23:0] loadBuf;
   logic [1:0]  loadLen;
   logic        goWb;
   logic        endWb;
   logic        ctrlWr;
   logic        txDone;

   assign rxReady  = (state == ST_IDLE) || (state == ST_ARGS);
   assign rxFire   = rxValid && rxReady;
   assign stateDbg = state;

   // Argument bytes including the one on the bus this cycle, so the last byte
   // can be used on the same edge that accepts it.
   assign newArgs = {argShift, rxData};
   assign hostAdr = (opR == OP_WRITE) ? newArgs[39:16] : newArgs[23:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      load      = 1'b0;
      loadBuf   = '0;
      loadLen   = '0;
      goWb      = 1'b0;
      endWb     = 1'b0;
      ctrlWr    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rxFire) begin
               case (rxData)
                  OP_WRITE, OP_READ, OP_CONTROL: nextState = ST_ARGS;
                  OP_STATUS: begin
                     load      = 1'b1;
                     loadBuf   = {OP_STATUS, statusReg};
                     loadLen   = 2'd3;
                     nextState = ST_RESP;
                  end
                  default: begin
                     load      = 1'b1;
                     loadBuf   = {REPLY_BAD_OP, 16'h0000};
                     loadLen   = 2'd1;
                     nextState = ST_RESP;
                  end
               endcase
            end
         end
         ST_ARGS: begin
            if (rxFire && (argCnt == 3'd1)) begin
               if (opR == OP_CONTROL) begin
                  ctrlWr    = 1'b1;
                  load      = 1'b1;
                  loadBuf   = {OP_CONTROL, 16'h0000};
                  loadLen   = 2'd1;
                  nextState = ST_RESP;
               end else begin
                  goWb      = 1'b1;
                  nextState = ST_WB;
               end
            end
         end
         ST_WB: begin
            // An ack on the timeout cycle still completes the transfer normally.
            if (wbAckI) begin
               endWb     = 1'b1;
               load      = 1'b1;
               loadBuf   = (opR == OP_READ) ? {OP_READ, wbDatI} : {OP_WRITE, 16'h0000};
               loadLen   = (opR == OP_READ) ? 2'd3 : 2'd1;
               nextState = ST_RESP;
            end else if (toCnt == WB_TIMEOUT) begin
               endWb     = 1'b1;
               load      = 1'b1;
               loadBuf   = {REPLY_TIMEOUT, 16'h0000};
               loadLen   = 2'd1;
               nextState = ST_RESP;
            end
         end
         ST_RESP: begin
            if (txDone) begin
               nextState = ST_IDLE;
            end
         end
         default: nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opR        <= '0;
         argCnt     <= '0;
         argShift   <= '0;
         toCnt      <= '0;
         wbAdrO     <= '0;
         wbDatO     <= '0;
         wbCycO     <= 1'b0;
         wbStbO     <= 1'b0;
         wbWeO      <= 1'b0;
         controlReg <= CONTROL_RESET;
      end else begin
         if ((state == ST_IDLE) && rxFire) begin
            opR      <= rxData;
            argCnt   <= argCount(rxData);
            argShift <= '0;
         end
         if ((state == ST_ARGS) && rxFire) begin
            argShift <= newArgs[31:0];
            argCnt   <= argCnt - 3'd1;
         end
         if (goWb) begin
            wbCycO <= 1'b1;
            wbStbO <= 1'b1;
            wbWeO  <= (opR == OP_WRITE);
            wbAdrO <= hostAdr[ADDRESS_WIDTH-1:0];
            wbDatO <= (opR == OP_WRITE) ? newArgs[15:0] : 16'h0000;
            toCnt  <= '0;
         end else if (state == ST_WB) begin
            if (endWb) begin
               wbCycO <= 1'b0;
               wbStbO <= 1'b0;
               wbWeO  <= 1'b0;
            end else begin
               toCnt <= toCnt + 16'd1;
            end
         end
         if (ctrlWr) begin
            controlReg <= newArgs[15:0];
         end
      end
   end

   host_reply_tx uReplyTx (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .loadBuf (loadBuf),
      .loadLen (loadLen),
      .txData  (txData),
      .txValid (txValid),
      .txReady (txReady),
      .done    (txDone)
   );

endmodule

// File: tb/tb_host_loader.sv
// Bench for host_loader: directed scenarios followed by random command frames,
// checked against a command-level reference model with a small memory.
module tb_host_loader;
   import host_loader_pkg::*;

   localparam int          AW  = 24;
   localparam logic [15:0] TMO = 16'd4;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    rxData;
   logic          rxValid;
   logic          rxReady;
   logic [7:0]    txData;
   logic          txValid;
   logic          txReady;
   logic [AW-1:0] wbAdrO;
   logic [15:0]   wbDatO;
   logic [15:0]   wbDatI = 16'h0000;
   logic          wbCycO;
   logic          wbStbO;
   logic          wbWeO;
   logic          wbAckI = 1'b0;
   logic [15:0]   controlReg;
   logic [15:0]   statusReg;
   logic [1:0]    stateDbg;

   always #5 clk = ~clk;

   host_loader #(
      .ADDRESS_WIDTH (AW),
      .WB_TIMEOUT    (TMO),
      .CONTROL_RESET (16'h0001)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rxData     (rxData),
      .rxValid    (rxValid),
      .rxReady    (rxReady),
      .txData     (txData),
      .txValid    (txValid),
      .txReady    (txReady),
      .wbAdrO     (wbAdrO),
      .wbDatO     (wbDatO),
      .wbDatI     (wbDatI),
      .wbCycO     (wbCycO),
      .wbStbO     (wbStbO),
      .wbWeO      (wbWeO),
      .wbAckI     (wbAckI),
      .controlReg (controlReg),
      .statusReg  (statusReg),
      .stateDbg   (stateDbg)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]  gotQ[$];
   logic [7:0]  expQ[$];

   // Reference model state
   logic [15:0] memM [logic [23:0]];
   logic [15:0] ctrlM;

   // Slave and host-side knobs
   int          ackDelay = 0;
   bit          noAck    = 1'b0;
   int          waitCnt  = 0;
   bit          txRand   = 1'b0;
   logic        txEn     = 1'b1;
   logic [15:0] slvMem [logic [23:0]];
   logic [23:0] firstAdr, lastAdr;
   logic [15:0] firstDat, lastDat;
   logic        firstWe, lastWe, lastStable;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Host reply sink
   always @(posedge clk) begin
      #1;
      txReady = txRand ? ($urandom_range(0, 3) != 0) : txEn;
   end

   always @(negedge clk) begin
      if (txValid === 1'b1 && txReady === 1'b1) gotQ.push_back(txData);
   end

   // Wishbone slave with programmable ack latency
   always @(posedge clk) begin
      #1;
      if (wbAckI) begin
         wbAckI = 1'b0;
      end else if (wbCycO === 1'b1 && wbStbO === 1'b1) begin
         if (waitCnt == 0) begin
            firstAdr = wbAdrO;
            firstDat = wbDatO;
            firstWe  = wbWeO;
         end
         if (!noAck && waitCnt >= ackDelay) begin
            wbAckI     = 1'b1;
            lastAdr    = wbAdrO;
            lastDat    = wbDatO;
            lastWe     = wbWeO;
            lastStable = (wbAdrO == firstAdr) && (wbDatO == firstDat) && (wbWeO == firstWe);
            if (wbWeO) slvMem[wbAdrO] = wbDatO;
            else wbDatI = slvMem.exists(wbAdrO) ? slvMem[wbAdrO] : 16'h0000;
            waitCnt = 0;
         end else begin
            waitCnt++;
         end
      end else begin
         waitCnt = 0;
      end
   end

   task automatic sendByte(input logic [7:0] b);
      bit ok;
      ok      = 1'b0;
      rxData  = b;
      rxValid = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (rxReady === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      rxValid = 1'b0;
      check("rx_accept", {31'd0, ok}, 32'd1);
   endtask

   task automatic expectReply(input string tag);
      int n;
      logic [7:0] e, g;
      n = 0;
      while (gotQ.size() < expQ.size() && n < 400) begin
         tick();
         n++;
      end
      check({tag, "_len"}, gotQ.size(), expQ.size());
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         g = (gotQ.size() > 0) ? gotQ.pop_front() : 8'hxx;
         check(tag, {24'd0, g}, {24'd0, e});
      end
      gotQ.delete();
   endtask

   task automatic sendAddr(input logic [23:0] a);
      sendByte(a[23:16]);
      sendByte(a[15:8]);
      sendByte(a[7:0]);
   endtask

   task automatic cmdWrite(input logic [23:0] a, input logic [15:0] d);
      sendByte(OP_WRITE);
      sendAddr(a);
      sendByte(d[15:8]);
      sendByte(d[7:0]);
      memM[a] = d;
      expQ.push_back(8'h01);
      expectReply("write_reply");
   endtask

   task automatic cmdRead(input logic [23:0] a);
      logic [15:0] v;
      v = memM.exists(a) ? memM[a] : 16'h0000;
      sendByte(OP_READ);
      sendAddr(a);
      expQ.push_back(8'h02);
      expQ.push_back(v[15:8]);
      expQ.push_back(v[7:0]);
      expectReply("read_reply");
   endtask

   task automatic cmdControl(input logic [15:0] d);
      sendByte(OP_CONTROL);
      sendByte(d[15:8]);
      sendByte(d[7:0]);
      ctrlM = d;
      expQ.push_back(8'h03);
      expectReply("control_reply");
      check("control_reg", {16'd0, controlReg}, {16'd0, ctrlM});
   endtask

   task automatic cmdStatus(input logic [15:0] s);
      statusReg = s;
      sendByte(OP_STATUS);
      expQ.push_back(8'h04);
      expQ.push_back(s[15:8]);
      expQ.push_back(s[7:0]);
      expectReply("status_reply");
   endtask

   task automatic cmdBad(input logic [7:0] op);
      sendByte(op);
      expQ.push_back(8'hEE);
      expectReply("bad_reply");
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] d0;
      int kind;
      logic [23:0] a;

      rst = 1'b1;
      rxData = 8'h00;
      rxValid = 1'b0;
      statusReg = 16'h0000;
      ctrlM = 16'h0001;
      repeat (3) tick();

      // Reset state
      check("rst_rxReady", {31'd0, rxReady}, 32'd1);
      check("rst_txValid", {31'd0, txValid}, 32'd0);
      check("rst_txData", {24'd0, txData}, 32'd0);
      check("rst_cyc_stb_we", {29'd0, wbCycO, wbStbO, wbWeO}, 32'd0);
      check("rst_adr", {8'd0, wbAdrO}, 32'd0);
      check("rst_dat", {16'd0, wbDatO}, 32'd0);
      check("rst_control", {16'd0, controlReg}, 32'h0001);
      rst = 1'b0;
      tick();

      // STATUS after reset
      cmdStatus(16'h0004);
      check("status_control", {16'd0, controlReg}, 32'h0001);

      // WRITE with a two-cycle slave
      ackDelay = 2;
      slvMem[24'h000007] = 16'hBEEF;
      memM[24'h000007] = 16'hBEEF;
      cmdWrite(24'h010005, 16'h1234);
      check("write_adr", {8'd0, lastAdr}, 32'h010005);
      check("write_dat", {16'd0, lastDat}, 32'h1234);
      check("write_we", {31'd0, lastWe}, 32'd1);
      check("write_stable", {31'd0, lastStable}, 32'd1);

      // READ
      cmdRead(24'h000007);
      check("read_we", {31'd0, lastWe}, 32'd0);
      check("read_adr", {8'd0, lastAdr}, 32'h000007);

      // Zero-wait WRITE: one Wishbone cycle, then reply
      ackDelay = 0;
      sendByte(OP_WRITE);
      sendAddr(24'h000030);
      sendByte(8'h55);
      sendByte(8'hAA);
      check("zw_cyc_rise", {31'd0, wbCycO}, 32'd1);
      tick();
      check("zw_cyc_drop", {31'd0, wbCycO}, 32'd0);
      check("zw_txValid", {31'd0, txValid}, 32'd1);
      memM[24'h000030] = 16'h55AA;
      expQ.push_back(8'h01);
      expectReply("zw_reply");

      // WRITE with no ack: timeout
      noAck = 1'b1;
      sendByte(OP_WRITE);
      sendAddr(24'h000020);
      sendByte(8'hAB);
      sendByte(8'hCD);
      n = 0;
      while (wbCycO === 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("tmo_cycles", {31'd0, (n >= int'(TMO)) && (n <= int'(TMO) + 1)}, 32'd1);
      expQ.push_back(8'hEF);
      expectReply("tmo_reply");
      noAck = 1'b0;
      cmdRead(24'h000020);

      // CONTROL and an unknown opcode
      cmdControl(16'h0000);
      cmdBad(8'h7A);

      // Reply back-pressure
      txEn = 1'b0;
      tick();
      tick();
      statusReg = 16'h00A5;
      sendByte(OP_STATUS);
      d0 = txData;
      check("hold_first", {24'd0, d0}, 32'h04);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_txData", {24'd0, txData}, {24'd0, d0});
         check("hold_rxReady", {31'd0, rxReady}, 32'd0);
         check("hold_txValid", {31'd0, txValid}, 32'd1);
      end
      txEn = 1'b1;
      expQ.push_back(8'h04);
      expQ.push_back(8'h00);
      expQ.push_back(8'hA5);
      expectReply("hold_reply");

      // Reset during the Wishbone phase
      noAck = 1'b1;
      sendByte(OP_WRITE);
      sendAddr(24'h000040);
      sendByte(8'h11);
      sendByte(8'h22);
      tick();
      tick();
      check("wbrst_pre_cyc", {31'd0, wbCycO}, 32'd1);
      rst = 1'b1;
      tick();
      ctrlM = 16'h0001;
      check("wbrst_cyc_stb", {30'd0, wbCycO, wbStbO}, 32'd0);
      check("wbrst_txValid", {31'd0, txValid}, 32'd0);
      check("wbrst_control", {16'd0, controlReg}, {16'd0, ctrlM});
      check("wbrst_rxReady", {31'd0, rxReady}, 32'd1);
      rst = 1'b0;
      noAck = 1'b0;
      tick();
      gotQ.delete();

      // Reset during the reply
      txEn = 1'b0;
      tick();
      tick();
      statusReg = 16'h0002;
      sendByte(OP_STATUS);
      check("resprst_pre_valid", {31'd0, txValid}, 32'd1);
      rst = 1'b1;
      tick();
      check("resprst_txValid", {31'd0, txValid}, 32'd0);
      check("resprst_txData", {24'd0, txData}, 32'd0);
      rst = 1'b0;
      txEn = 1'b1;
      tick();
      tick();
      gotQ.delete();
      cmdStatus(16'h0001);
      cmdRead(24'h000040);

      // Random command frames with random slave latency and reply back-pressure
      txRand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 4);
         ackDelay = $urandom_range(0, 3);
         a = 24'h000100 + 24'($urandom_range(0, 7));
         case (kind)
            0: cmdWrite(a, 16'($urandom_range(0, 65535)));
            1: cmdRead(a);
            2: cmdControl(16'($urandom_range(0, 65535)));
            3: cmdStatus(16'($urandom_range(0, 7)));
            default: cmdBad(8'($urandom_range(5, 255)));
         endcase
      end
      txRand = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/host_loader.md
# host_loader

Host-side command bridge that sits upstream of the test processor. It takes a byte stream from the host link (valid/ready), and uses it to load program memory and poke registers through its own Wishbone master port. It also drives the processor's `controlReg` input and reports its `statusReg` output. Every host command returns a fixed-format reply on a byte-stream output.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 24: Wishbone address width. Only the low `ADDRESS_WIDTH` bits of the 24-bit host address are used.
- `WB_TIMEOUT`, 1023: maximum cycles to wait for `wbAckI` before aborting a transfer; 16-bit value.
- `CONTROL_RESET`, 16'h0001: reset value of `controlReg`. The processor is halted out of reset.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `rxData` in 8: command byte from the host.
- `rxValid` in 1: `rxData` is valid.
- `rxReady` out 1: bridge accepts the byte.
- `txData` out 8: reply byte.
- `txValid` out 1: `txData` is valid.
- `txReady` in 1: host accepts the reply byte.
- `wbAdrO` out `ADDRESS_WIDTH`: Wishbone address.
- `wbDatO` out 16: Wishbone write data.
- `wbDatI` in 16: Wishbone read data.
- `wbCycO` out 1: Wishbone cycle.
- `wbStbO` out 1: Wishbone strobe.
- `wbWeO` out 1: Wishbone write enable.
- `wbAckI` in 1: Wishbone acknowledge.
- `controlReg` out 16: to the processor; bit 0 = halt.
- `statusReg` in 16: from the processor, `{13'd0, running, failed, succeeded}`.

## Operation
- Byte handshake: a transfer occurs on a cycle where valid && ready, on both rx and tx.
- Multi-byte fields are big-endian. Addresses are 3 bytes and data is 2 bytes.
- Commands (opcode, args -> reply):
  - 0x01 WRITE, `addr[3] data[2]` -> Wishbone write -> reply `01`.
  - 0x02 READ, `addr[3]` -> Wishbone read -> reply `02 dH dL`.
  - 0x03 CONTROL, `data[2]` -> `controlReg` <= data -> reply `03`.
  - 0x04 STATUS, no args -> reply `04 sH sL`. `statusReg` is sampled on the cycle the opcode is accepted.
  - Any other opcode is consumed and gets reply `EE`.
  - Wishbone timeout gets reply `EF`; the command has no other effect.
- States:
  - IDLE: `rxReady`=1. On accepting an opcode, go to ARGS with argument count 5, 3 or 2. With no arguments, go to RESP.
  - ARGS: `rxReady`=1. A shift register collects the argument bytes and a counter decrements on each accepted byte. After the last byte, go to WB for WRITE/READ, or apply CONTROL and go to RESP.
  - WB: `wbCycO`=`wbStbO`=1, `wbWeO`=1 for WRITE. `wbAdrO`/`wbDatO` are stable for the whole cycle.
    - On `wbAckI`: capture `wbDatI` (READ), drop cyc/stb/we on the next edge, go to RESP.
    - Timeout counter reaches `WB_TIMEOUT` without an ack: drop the cycle and reply `EF`.
  - RESP: `txValid`=1. A byte index walks the reply; `txData` is held while `!txReady`. After the last byte is accepted, return to IDLE.
- Only one frame is in flight at a time. No pipelining, and no new opcode is accepted until the reply completes.
- `rxReady`=0 in WB and RESP. Host bytes are back-pressured, never dropped.

## Timing
- Reset values: IDLE; `rxReady`=1, `txValid`=0, `txData`=0; `wbCycO`/`wbStbO`/`wbWeO`=0, `wbAdrO`=0, `wbDatO`=0; `controlReg`=`CONTROL_RESET`.
- `rst` mid-frame (any state): all of the above on the next edge. A Wishbone cycle in flight is abandoned with cyc low at once; the partial frame and reply are discarded.
- Wishbone outputs are registered:
  - cyc/stb rise on the edge after the last argument byte is accepted.
  - An ack sampled on edge N means cyc/stb are low after N and `txValid` is high after N.
  - Zero-wait slave: a 5-byte WRITE arg phase, then 1 WB cycle, then RESP.
- The timeout counter is 16 bits, cleared on entering WB, incremented each WB cycle without ack. Abort happens when counter == `WB_TIMEOUT`. An ack on that same cycle wins (normal reply).
- `controlReg` updates on the edge after the final CONTROL data byte; the reply starts on the same edge.
- `txValid` goes high the cycle after entering RESP is decided. Reply bytes can issue back-to-back at one per cycle when `txReady`=1.

## Structure
- Shared package `host_loader_pkg`: opcode constants 0x01–0x04, reply codes `EE`/`EF`, and state encoding.
- Optional sub-module `host_reply_tx`: reply serializer taking a 3-byte buffer and a length, producing valid/ready output. Everything else stays in one module of about 250 lines.

## Test plan
- Reset, then STATUS with `statusReg`=0x0004 -> reply `04 00 04`; `controlReg`=0x0001 throughout.
- WRITE `01 01 00 05 12 34`, slave acks after 2 cycles -> `wbAdrO`=0x010005, `wbDatO`=0x1234, `wbWeO`=1 held until ack; reply `01`.
- READ `02 00 00 07` with slave returning 0xBEEF -> reply `02 BE EF`; `wbWeO`=0.
- WRITE with no ack, `WB_TIMEOUT`=4 -> cyc drops after 4 cycles, reply `EF`; next command works normally.
- CONTROL `03 00 00` -> `controlReg`=0x0000, reply `01`-free `03`. Opcode `7A` -> reply `EE`. With `txReady` low for 3 cycles, `txData` stays stable and `rxReady` stays 0.
- `rst` pulsed during the WB phase and during RESP -> cyc/stb low and `txValid` low next cycle; `controlReg`=0x0001; a fresh STATUS succeeds.
